axis_rr_merge: RTL and testbench
================================

# axis_rr_merge

Three-to-one AXI-Stream merger with packet-level round-robin arbitration. Sits directly downstream of the tdest router and recombines its three master streams (m0/m1/m2) into a single stream. The source index is tagged onto tid, and beats of one packet are never interleaved with another source. The output is fully registered, and the block sustains one beat per cycle, including back-to-back single-beat packets.

## Interface
- DATA_WIDTH, 8, tdata width in bits
- DEST_WIDTH, 2, tdest width in bits; passed through unchanged
- s_axis_aclk  in  1  single clock; all logic on rising edge
- s_axis_aresetn  in  1  reset, asynchronous assert, active-low
- sN_axis_tvalid, N=0..2  in  1  source N beat valid
- sN_axis_tready, N=0..2  out  1  source N beat accepted when tvalid && tready
- sN_axis_tdata  in  DATA_WIDTH  source N data
- sN_axis_tkeep  in  1  source N keep
- sN_axis_tlast  in  1  source N end of packet
- sN_axis_tdest  in  DEST_WIDTH  source N destination
- m_axis_tvalid  out  1  merged beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  DATA_WIDTH  merged data
- m_axis_tkeep  out  1  merged keep
- m_axis_tlast  out  1  merged end of packet
- m_axis_tdest  out  DEST_WIDTH  copied from the winning source
- m_axis_tid  out  2  index of the source the beat came from (0..2)

## Operation
- Output register: holds one beat (valid, data, keep, last, dest, id). It can load when !m_axis_tvalid || m_axis_tready, called `room`.
- State machine:
  - IDLE: no owner. Combinational round-robin pick among sources with tvalid=1, searching from (last_grant+1) mod 3 upward with wrap.
    - Only the picked source gets tready=room. All others get 0.
  - LOCK(owner): only the owner gets tready=room. Other sources are ignored regardless of tvalid.
- On any accepted beat from source g: load the output register with g's fields and tid=g, and set last_grant<=g.
- Transitions:
  - IDLE -> LOCK(g) when the accepted beat has tlast=0.
  - IDLE stays IDLE when the accepted beat has tlast=1, i.e. a single-beat packet. The next pick rotates the following cycle.
  - LOCK -> IDLE when an owner beat with tlast=1 is accepted.
  - LOCK holds while the owner is idle (tvalid=0). There is no timeout.
- Output register update when room=1:
  - If no beat is accepted, m_axis_tvalid<=0 and the other output fields hold their values.
  - When room=0, the output register holds all fields.
- tready never depends on m_axis_tvalid of the same cycle except through room. No combinational path runs from sN_axis_tdata to the outputs.
- owner and last_grant never take value 3. If an encoding of 3 is reached, treat it as IDLE with last_grant=2.

## Timing
- Reset (async assert, released synchronously to the clock edge):
  - m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0, tdest=0, tid=0.
  - State IDLE, last_grant=2, so s0 has first priority.
  - All sN_axis_tready=0 while reset is asserted.
- Reset asserted mid-packet: the packet is dropped. The register contents are lost, and after release arbitration restarts from s0.
- Latency: 1 cycle from source acceptance to m_axis_tvalid=1.
- Throughput: 1 beat/cycle while m_axis_tready=1. No bubble between packets, including alternating single-beat packets from different sources.
- Backpressure: with m_axis_tready=0 and m_axis_tvalid=1, all sN_axis_tready=0 in the same cycle. Output fields stay stable until accepted.
- Fairness: with all three sources continuously valid and every packet of length L, the grant order is 0,1,2,0,... at packet granularity.
- Simultaneous events in one cycle are all honoured:
  - an output beat leaves while a new beat loads;
  - tlast is accepted and last_grant is updated together.

## Test plan
- Reset, then s0 sends one beat (data=0x11, tlast=1, tdest=1) with m_axis_tready=1. Required: m_axis_tvalid=1 exactly one cycle later, with data=0x11, tdest=1, tid=0, tlast=1.
- All three sources continuously send single-beat packets; s0 data 0x00.., s1 data 0x40.., s2 data 0x80... Required: m_axis_tid sequence 0,1,2,0,1,2 with no idle cycle, and the data of each source appears in order.
- s1 sends a 4-beat packet (0x20..0x23, tlast on 0x23) while s0 and s2 are held valid. Required:
  - four consecutive beats with tid=1 appear, not interleaved with other sources;
  - the next packet is from s2 (tid=2), then s0.
- m_axis_tready toggles 1,0,0,1 during a 3-source stream. Required:
  - all sN_axis_tready=0 whenever m_axis_tvalid=1 and m_axis_tready=0;
  - no beat is lost or duplicated;
  - output fields stay stable while stalled.
- s2 is owner mid-packet (2 of 5 beats sent), and s2 tvalid drops for 3 cycles while s0 is valid. Required: s0_axis_tready=0 throughout, and s2 resumes and completes its packet before s0 is granted.
- Assert s_axis_aresetn=0 mid-packet from s1. Required:
  - all outputs are at reset values immediately, without waiting for a clock edge;
  - after release, the first grant with all sources valid goes to s0.

Source files
------------

// File: rtl/axis_rr_merge.sv
// Three-to-one AXI-Stream merger with packet-level round-robin arbitration.
// The source index is tagged onto tid; the output beat is fully registered.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner; round-robin pick from (last_grant+1) mod 3 upward
// LOCK    | owner holds the output until it delivers a beat with tlast
module axis_rr_merge #(
  parameter int DATA_WIDTH = 8,
  parameter int DEST_WIDTH = 2
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,

  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tkeep,
  input  logic                  s0_axis_tlast,
  input  logic [DEST_WIDTH-1:0] s0_axis_tdest,

  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tkeep,
  input  logic                  s1_axis_tlast,
  input  logic [DEST_WIDTH-1:0] s1_axis_tdest,

  input  logic                  s2_axis_tvalid,
  output logic                  s2_axis_tready,
  input  logic [DATA_WIDTH-1:0] s2_axis_tdata,
  input  logic                  s2_axis_tkeep,
  input  logic                  s2_axis_tlast,
  input  logic [DEST_WIDTH-1:0] s2_axis_tdest,

  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [1:0]            m_axis_tid
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_grant_q, last_grant_d;

  // Slot 3 is a never-valid dummy source so a 2-bit index is always in range.
  logic [3:0]            src_valid;
  logic [3:0]            src_keep;
  logic [3:0]            src_last;
  logic [DATA_WIDTH-1:0] src_data [4];
  logic [DEST_WIDTH-1:0] src_dest [4];

  assign src_valid = {1'b0, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
  assign src_keep  = {1'b0, s2_axis_tkeep,  s1_axis_tkeep,  s0_axis_tkeep};
  assign src_last  = {1'b0, s2_axis_tlast,  s1_axis_tlast,  s0_axis_tlast};
  assign src_data[0] = s0_axis_tdata;
  assign src_data[1] = s1_axis_tdata;
  assign src_data[2] = s2_axis_tdata;
  assign src_data[3] = '0;
  assign src_dest[0] = s0_axis_tdest;
  assign src_dest[1] = s1_axis_tdest;
  assign src_dest[2] = s2_axis_tdest;
  assign src_dest[3] = '0;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    inc3 = (x == 2'd2 || x == 2'd3) ? 2'd0 : x + 2'd1;
  endfunction

  logic       room;
  logic       locked;
  logic [1:0] lg_eff;
  logic [1:0] cand0, cand1, cand2;
  logic [1:0] pick;
  logic       pick_vld;
  logic [1:0] sel;
  logic       grant_en;
  logic [3:0] tready;
  logic       accept;
  logic       acc_last;

  assign room   = !m_axis_tvalid || m_axis_tready;
  // An illegal owner/last_grant encoding of 3 decays to IDLE / last_grant=2.
  assign locked = (state_q == ST_LOCK) && (owner_q != 2'd3);
  assign lg_eff = (last_grant_q == 2'd3) ? 2'd2 : last_grant_q;
  assign cand0  = inc3(lg_eff);
  assign cand1  = inc3(cand0);
  assign cand2  = inc3(cand1);

  always_comb begin
    pick     = cand2;
    pick_vld = |src_valid;
    if (src_valid[cand1]) pick = cand1;
    if (src_valid[cand0]) pick = cand0;
  end

  assign sel      = locked ? owner_q : pick;
  assign grant_en = room && (locked || pick_vld) && s_axis_aresetn;
  assign accept   = |(src_valid & tready);
  assign acc_last = src_last[sel];

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= 2'd0;
      last_grant_q <= 2'd2;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = locked ? ST_LOCK : ST_IDLE;
    owner_d      = locked ? owner_q : 2'd0;
    last_grant_d = lg_eff;
    if (accept) begin
      last_grant_d = sel;
      if (acc_last) begin
        state_d = ST_IDLE;
        owner_d = 2'd0;
      end else begin
        state_d = ST_LOCK;
        owner_d = sel;
      end
    end
  end

  always_comb begin
    tready = 4'b0000;
    if (grant_en) tready[sel] = 1'b1;
  end

  assign s0_axis_tready = tready[0];
  assign s1_axis_tready = tready[1];
  assign s2_axis_tready = tready[2];

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdest  <= '0;
      m_axis_tid    <= 2'd0;
    end else if (room) begin
      m_axis_tvalid <= accept;
      if (accept) begin
        m_axis_tdata <= src_data[sel];
        m_axis_tkeep <= src_keep[sel];
        m_axis_tlast <= acc_last;
        m_axis_tdest <= src_dest[sel];
        m_axis_tid   <= sel;
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_merge.sv
// Directed bench for axis_rr_merge: per-source beat queues feed the DUT,
// output beats are logged and compared against hand-written sequences.
module tb_axis_rr_merge;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic       clk;
  logic       aresetn;
  logic [2:0] s_tvalid;
  logic [7:0] s_tdata [3];
  logic [2:0] s_tkeep;
  logic [2:0] s_tlast;
  logic [1:0] s_tdest [3];
  wire        rdy0, rdy1, rdy2;
  wire  [2:0] s_tready = {rdy2, rdy1, rdy0};
  wire        m_tvalid;
  logic       m_tready;
  wire  [7:0] m_tdata;
  wire        m_tkeep;
  wire        m_tlast;
  wire  [1:0] m_tdest;
  wire  [1:0] m_tid;

  axis_rr_merge #(.DATA_WIDTH(8), .DEST_WIDTH(2)) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (aresetn),
    .s0_axis_tvalid (s_tvalid[0]),
    .s0_axis_tready (rdy0),
    .s0_axis_tdata  (s_tdata[0]),
    .s0_axis_tkeep  (s_tkeep[0]),
    .s0_axis_tlast  (s_tlast[0]),
    .s0_axis_tdest  (s_tdest[0]),
    .s1_axis_tvalid (s_tvalid[1]),
    .s1_axis_tready (rdy1),
    .s1_axis_tdata  (s_tdata[1]),
    .s1_axis_tkeep  (s_tkeep[1]),
    .s1_axis_tlast  (s_tlast[1]),
    .s1_axis_tdest  (s_tdest[1]),
    .s2_axis_tvalid (s_tvalid[2]),
    .s2_axis_tready (rdy2),
    .s2_axis_tdata  (s_tdata[2]),
    .s2_axis_tkeep  (s_tkeep[2]),
    .s2_axis_tlast  (s_tlast[2]),
    .s2_axis_tdest  (s_tdest[2]),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tlast   (m_tlast),
    .m_axis_tdest   (m_tdest),
    .m_axis_tid     (m_tid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  beat_t       srcq [3][$];
  logic [2:0]  hold;
  logic        bp_mode;
  logic [3:0]  bp_pat = 4'b1001;
  logic        s0_block;
  logic [13:0] got_q [$];
  logic [13:0] exp_q [$];
  int          got_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int src, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    srcq[src].push_back(b);
  endtask

  // Expected output beat {keep, dest, id, last, data}; dest is sent as data[1:0].
  task automatic expb(input logic [1:0] id, input logic [7:0] d, input logic l);
    exp_q.push_back({1'b1, d[1:0], id, l, d});
  endtask

  task automatic present();
    for (int i = 0; i < 3; i++) begin
      if (srcq[i].size() > 0 && !hold[i]) begin
        s_tvalid[i] = 1'b1;
        s_tdata[i]  = srcq[i][0].d;
        s_tlast[i]  = srcq[i][0].l;
        s_tdest[i]  = srcq[i][0].d[1:0];
        s_tkeep[i]  = 1'b1;
      end else begin
        s_tvalid[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    logic [2:0]  hs;
    logic        stalled;
    logic [13:0] snap;
    if (bp_mode) m_tready = bp_pat[cyc % 4];
    present();
    #1;
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      got_q.push_back({m_tkeep, m_tdest, m_tid, m_tlast, m_tdata});
      got_cyc.push_back(cyc);
    end
    stalled = m_tvalid && !m_tready;
    if (stalled) chk("bp_src_ready", 32'(s_tready), 32'd0);
    if (s0_block) chk("s0_blocked", 32'(s_tready[0]), 32'd0);
    snap = {m_tkeep, m_tdest, m_tid, m_tlast, m_tdata};
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) if (hs[i]) void'(srcq[i].pop_front());
    if (stalled)
      chk("stall_hold", 32'({m_tvalid, m_tkeep, m_tdest, m_tid, m_tlast, m_tdata}),
          32'({1'b1, snap}));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size() != 0 || m_tvalid) && n < 300) begin
      cycle();
      n++;
    end
    chk({tag, "_drain_bound"}, 32'(n < 300), 32'd1);
  endtask

  task automatic check_seq(input string tag, input bit nobub);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    if (nobub)
      for (int i = 1; i < got_cyc.size(); i++)
        chk($sformatf("%s_gap%0d", tag, i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd1);
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  // Asserts reset immediately and checks the asynchronous effect before any edge.
  task automatic do_reset(input string tag);
    aresetn = 1'b0;
    #1;
    chk({tag, "_rst_out"}, 32'({m_tvalid, m_tkeep, m_tdest, m_tid, m_tlast, m_tdata}), 32'd0);
    chk({tag, "_rst_rdy"}, 32'(s_tready), 32'd0);
    for (int i = 0; i < 3; i++) srcq[i].delete();
    hold     = 3'b000;
    bp_mode  = 1'b0;
    s0_block = 1'b0;
    m_tready = 1'b1;
    present();
    @(posedge clk);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    aresetn  = 1'b0;
    s_tvalid = 3'b000;
    s_tkeep  = 3'b000;
    s_tlast  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      s_tdata[i] = 8'h00;
      s_tdest[i] = 2'd0;
    end
    hold     = 3'b000;
    bp_mode  = 1'b0;
    s0_block = 1'b0;
    m_tready = 1'b1;

    // Single beat latency and field routing
    do_reset("t1");
    push(0, 8'h11, 1'b1);
    present();
    #1;
    chk("t1_pre_valid", 32'(m_tvalid), 32'd0);
    chk("t1_s0_ready", 32'(s_tready), 32'b001);
    cycle();
    chk("t1_valid", 32'(m_tvalid), 32'd1);
    chk("t1_data", 32'(m_tdata), 32'h11);
    chk("t1_dest", 32'(m_tdest), 32'd1);
    chk("t1_tid", 32'(m_tid), 32'd0);
    chk("t1_last", 32'(m_tlast), 32'd1);
    chk("t1_keep", 32'(m_tkeep), 32'd1);
    drain("t1");
    expb(0, 8'h11, 1);
    check_seq("t1", 1'b0);

    // Back-to-back single-beat packets from all three sources
    do_reset("t2");
    for (int k = 0; k < 3; k++) begin
      push(0, 8'h00 + 8'(k), 1'b1);
      push(1, 8'h40 + 8'(k), 1'b1);
      push(2, 8'h80 + 8'(k), 1'b1);
    end
    drain("t2");
    expb(0, 8'h00, 1); expb(1, 8'h40, 1); expb(2, 8'h80, 1);
    expb(0, 8'h01, 1); expb(1, 8'h41, 1); expb(2, 8'h81, 1);
    expb(0, 8'h02, 1); expb(1, 8'h42, 1); expb(2, 8'h82, 1);
    check_seq("t2", 1'b1);

    // Multi-beat packet from s1 locks out s0 and s2
    do_reset("t3");
    push(0, 8'hA0, 1'b1);
    push(0, 8'hA1, 1'b1);
    push(1, 8'h20, 1'b0);
    push(1, 8'h21, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h23, 1'b1);
    push(2, 8'hC0, 1'b1);
    drain("t3");
    expb(0, 8'hA0, 1);
    expb(1, 8'h20, 0); expb(1, 8'h21, 0); expb(1, 8'h22, 0); expb(1, 8'h23, 1);
    expb(2, 8'hC0, 1);
    expb(0, 8'hA1, 1);
    check_seq("t3", 1'b1);

    // Downstream backpressure pattern 1,0,0,1
    do_reset("t4");
    for (int k = 1; k < 3; k++) begin
      push(0, 8'h00 + 8'(k), 1'b1);
      push(1, 8'h40 + 8'(k), 1'b1);
      push(2, 8'h80 + 8'(k), 1'b1);
    end
    bp_mode = 1'b1;
    drain("t4");
    bp_mode  = 1'b0;
    m_tready = 1'b1;
    expb(0, 8'h01, 1); expb(1, 8'h41, 1); expb(2, 8'h81, 1);
    expb(0, 8'h02, 1); expb(1, 8'h42, 1); expb(2, 8'h82, 1);
    check_seq("t4", 1'b0);

    // Owner s2 pauses mid-packet; s0 must wait
    do_reset("t5");
    hold = 3'b001;
    for (int k = 0; k < 5; k++) push(2, 8'hE0 + 8'(k), k == 4);
    push(0, 8'h05, 1'b1);
    cycle();
    cycle();
    hold     = 3'b100;
    s0_block = 1'b1;
    repeat (3) cycle();
    s0_block = 1'b0;
    hold     = 3'b000;
    drain("t5");
    for (int k = 0; k < 5; k++) expb(2, 8'hE0 + 8'(k), k == 4);
    expb(0, 8'h05, 1);
    check_seq("t5", 1'b0);

    // Reset in the middle of an s1 packet
    do_reset("t6a");
    hold = 3'b101;
    push(0, 8'h09, 1'b1);
    push(2, 8'h89, 1'b1);
    push(1, 8'h30, 1'b0);
    push(1, 8'h31, 1'b0);
    push(1, 8'h32, 1'b0);
    push(1, 8'h33, 1'b1);
    cycle();
    cycle();
    chk("t6_pre_valid", 32'(m_tvalid), 32'd1);
    chk("t6_pre_data", 32'(m_tdata), 32'h31);
    hold = 3'b000;
    present();
    #2;
    do_reset("t6");
    push(0, 8'h07, 1'b1);
    push(1, 8'h37, 1'b1);
    push(2, 8'h87, 1'b1);
    drain("t6");
    expb(0, 8'h07, 1); expb(1, 8'h37, 1); expb(2, 8'h87, 1);
    check_seq("t6", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
